// File: rtl/rv_burst_tx_pkg.sv
// Shared encodings and default widths for the valid/ready burst path.
// Imported by the burst transmitter, its interface, and the benches.
package rv_burst_tx_pkg;

  localparam int unsigned RV_WD = 4;
  localparam int unsigned RV_LW = 4;

  typedef enum logic [0:0] {
    RV_IDLE = 1'b0,
    RV_SEND = 1'b1
  } rv_state_e;

endpackage

// File: rtl/rv_burst_tx_if.sv
// Command and data-stream handshake bundle for rv_burst_tx.
// The master modport is the transmitter side; slave is the command source and data sink.
interface rv_burst_tx_if
  import rv_burst_tx_pkg::*;
#(
  parameter int unsigned wd = RV_WD,
  parameter int unsigned lw = RV_LW
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [wd-1:0] cmd_base;
  logic [lw-1:0] cmd_len;
  logic          abort;
  logic          m_valid;
  logic          s_ready;
  logic [wd-1:0] data_out;
  logic          m_last;
  logic          done;

  modport master (
    input  cmd_valid,
    input  cmd_base,
    input  cmd_len,
    input  abort,
    input  s_ready,
    output cmd_ready,
    output m_valid,
    output data_out,
    output m_last,
    output done
  );

  modport slave (
    output cmd_valid,
    output cmd_base,
    output cmd_len,
    output abort,
    output s_ready,
    input  cmd_ready,
    input  m_valid,
    input  data_out,
    input  m_last,
    input  done
  );

endinterface

// File: rtl/rv_burst_tx.sv
// Valid/ready burst transmitter: accepts (base, len) and streams len+1 incrementing beats,
// holding each beat under back-pressure; abort marks the presented beat as last.
module rv_burst_tx
  import rv_burst_tx_pkg::*;
#(
  parameter int unsigned wd = RV_WD,
  parameter int unsigned lw = RV_LW
) (
  input  logic           clk,
  input  logic           rst,
  rv_burst_tx_if.master  bus
);

  rv_state_e     state;
  rv_state_e     state_next;
  logic [wd-1:0] data_q;
  logic [lw-1:0] remain;
  logic          abort_pend;
  logic          done_q;

  logic          cmd_ready;
  logic          m_valid;
  logic          m_last;
  logic          accept;
  logic          xfer;

  assign accept = bus.cmd_valid && cmd_ready;
  assign xfer   = m_valid && bus.s_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      RV_IDLE: if (accept)          state_next = RV_SEND;
      RV_SEND: if (xfer && m_last)  state_next = RV_IDLE;
      default:                      state_next = RV_IDLE;
    endcase
  end

  // Output decode; m_valid depends on state only, never on s_ready
  always_comb begin
    cmd_ready = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    case (state)
      RV_IDLE: cmd_ready = !rst;
      RV_SEND: begin
        m_valid = 1'b1;
        m_last  = (remain == '0) || abort_pend;
      end
      default: ;
    endcase
  end

  // Beat data, remaining count, abort flag and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      remain     <= '0;
      abort_pend <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        RV_IDLE: begin
          if (accept) begin
            data_q     <= bus.cmd_base;
            remain     <= bus.cmd_len;
            abort_pend <= 1'b0;
          end
        end
        RV_SEND: begin
          if (bus.abort) begin
            abort_pend <= 1'b1;
          end
          // A final transfer wins over a coincident abort so the flag never leaks into IDLE
          if (xfer) begin
            if (m_last) begin
              done_q     <= 1'b1;
              abort_pend <= 1'b0;
            end else begin
              data_q <= data_q + wd'(1);
              remain <= remain - lw'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.m_valid   = m_valid;
  assign bus.m_last    = m_last;
  assign bus.data_out  = data_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_rv_burst_tx.sv
// Directed bench for rv_burst_tx: basic, back-pressure, wrap, abort, back-to-back, reset mid-burst.
module tb_rv_burst_tx;
  import rv_burst_tx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  rv_burst_tx_if bus ();

  rv_burst_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [3:0] d, input logic last);
    chk({tag, "_valid"}, 32'(bus.m_valid), 32'(1));
    chk({tag, "_data"},  32'(bus.data_out), 32'(d));
    chk({tag, "_last"},  32'(bus.m_last), 32'(last));
  endtask

  task automatic chk_idle(input string tag, input logic dn);
    chk({tag, "_valid"},     32'(bus.m_valid), 32'(0));
    chk({tag, "_done"},      32'(bus.done), 32'(dn));
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'(1));
  endtask

  task automatic send_cmd(input logic [3:0] base, input logic [3:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_basic(input string tag);
    bus.s_ready = 1'b1;
    send_cmd(4'd5, 4'd2);
    chk_beat({tag, "_b0"}, 4'd5, 1'b0);
    chk({tag, "_cmd_ready_send"}, 32'(bus.cmd_ready), 32'(0));
    tick();
    chk_beat({tag, "_b1"}, 4'd6, 1'b0);
    tick();
    chk_beat({tag, "_b2"}, 4'd7, 1'b1);
    tick();
    chk_idle({tag, "_end"}, 1'b1);
    tick();
    chk({tag, "_done_clr"}, 32'(bus.done), 32'(0));
  endtask

  logic [3:0] wrap_exp [4];

  initial begin
    wrap_exp = '{4'd14, 4'd15, 4'd0, 4'd1};
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.abort     = 1'b0;
    bus.s_ready   = 1'b0;
    #2;
    chk("rst_valid",     32'(bus.m_valid), 32'(0));
    chk("rst_data",      32'(bus.data_out), 32'(0));
    chk("rst_last",      32'(bus.m_last), 32'(0));
    chk("rst_done",      32'(bus.done), 32'(0));
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    tick();
    rst = 1'b0;
    #1;
    chk_idle("post_rst", 1'b0);

    run_basic("basic");

    // Back-pressure: each beat stalled one cycle, then transferred once
    bus.s_ready = 1'b0;
    send_cmd(4'd10, 4'd3);
    for (int i = 0; i < 4; i++) begin
      chk_beat("bp_pre", 4'(10 + i), i == 3);
      tick();
      chk_beat("bp_hold", 4'(10 + i), i == 3);
      bus.s_ready = 1'b1;
      tick();
      bus.s_ready = 1'b0;
    end
    chk_idle("bp_end", 1'b1);
    tick();

    // Wrap past 15
    bus.s_ready = 1'b1;
    send_cmd(4'd14, 4'd3);
    for (int i = 0; i < 4; i++) begin
      chk_beat("wrap", wrap_exp[i], i == 3);
      tick();
    end
    chk_idle("wrap_end", 1'b1);
    tick();

    // Abort while beat 3 stalled
    send_cmd(4'd0, 4'd15);
    for (int i = 0; i < 3; i++) begin
      chk_beat("ab_run", 4'(i), 1'b0);
      tick();
    end
    bus.s_ready = 1'b0;
    chk_beat("ab_b3", 4'd3, 1'b0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_beat("ab_mark", 4'd3, 1'b1);
    tick();
    chk_beat("ab_hold", 4'd3, 1'b1);
    bus.s_ready = 1'b1;
    tick();
    chk_idle("ab_end", 1'b1);
    tick();
    chk("ab_no_b4", 32'(bus.m_valid), 32'(0));
    chk("ab_done_clr", 32'(bus.done), 32'(0));

    // Back-to-back single-beat bursts with cmd_valid held high
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = 4'd8;
    bus.cmd_len   = 4'd0;
    tick();
    chk_beat("b2b_a", 4'd8, 1'b1);
    chk("b2b_a_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    bus.cmd_base = 4'd9;
    tick();
    chk_idle("b2b_gap", 1'b1);
    tick();
    chk_beat("b2b_b", 4'd9, 1'b1);
    chk("b2b_b_done", 32'(bus.done), 32'(0));
    chk("b2b_b_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    bus.cmd_valid = 1'b0;
    tick();
    chk_idle("b2b_end", 1'b1);
    tick();
    chk("b2b_quiet_valid", 32'(bus.m_valid), 32'(0));
    chk("b2b_quiet_done", 32'(bus.done), 32'(0));

    // Asynchronous reset during beat 2 of a 5-beat burst
    send_cmd(4'd2, 4'd4);
    chk_beat("mr_b0", 4'd2, 1'b0);
    tick();
    chk_beat("mr_b1", 4'd3, 1'b0);
    tick();
    chk_beat("mr_b2", 4'd4, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("mr_valid",     32'(bus.m_valid), 32'(0));
    chk("mr_data",      32'(bus.data_out), 32'(0));
    chk("mr_last",      32'(bus.m_last), 32'(0));
    chk("mr_done",      32'(bus.done), 32'(0));
    chk("mr_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    tick();
    rst = 1'b0;
    #1;
    chk_idle("mr_release", 1'b0);
    tick();
    chk("mr_no_done", 32'(bus.done), 32'(0));
    run_basic("mr_basic");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv_burst_tx.md
# rv_burst_tx

Valid/ready burst transmitter: the master end of the team's valid-ready handshake. It accepts a burst command (base value, beat count) on a command handshake, then drives an incrementing data stream on `m_valid`/`data_out` toward a downstream slave (e.g. the `rv1` register stage) that back-pressures via `s_ready`. It is the stimulus/source side of the handshake path and must never violate valid-ready rules under arbitrary back-pressure.

## Interface
- `wd`, 4, data width of `data_out` and `cmd_base`
- `lw`, 4, width of `cmd_len`; burst length is `cmd_len + 1` beats (1 to 2^lw)

- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted this cycle when both high
- `cmd_base`  in  wd  first data value of the burst
- `cmd_len`  in  lw  beats minus one
- `abort`  in  1  truncate current burst (see Operation)
- `m_valid`  out  1  `data_out` valid toward slave
- `s_ready`  in  1  slave can accept
- `data_out`  out  wd  beat data
- `m_last`  out  1  current beat is final beat of burst
- `done`  out  1  one-cycle pulse after final beat transfers

## Operation
- Two states: IDLE, SEND.
- IDLE: `cmd_ready = 1` (forced 0 while `rst` high). On `cmd_valid && cmd_ready`: latch `data_out <= cmd_base`, `remain <= cmd_len`, go SEND.
- SEND: `m_valid = 1`, `cmd_ready = 0`, commands ignored. Beat transfers on `m_valid && s_ready`.
  - Transfer with `remain != 0`: `data_out <= data_out + 1` (modulo 2^wd, 15 wraps to 0 at wd=4), `remain <= remain - 1`.
  - Transfer with `m_last`: go IDLE, `m_valid` drops, `done` pulses.
- `m_last = (state==SEND) && (remain==0 || abort_pend)`.
- Abort: `abort` sampled high in SEND sets `abort_pend`; the beat currently presented is not withdrawn or altered, only `m_last` rises; burst ends when that beat transfers. `abort` in IDLE ignored. `abort_pend` cleared on return to IDLE.
- Stall: while `m_valid && !s_ready`, `data_out`, `m_last` (except abort-induced rise) and `m_valid` hold.
- Reset (any time, including mid-burst): immediately state IDLE, `m_valid=0`, `data_out=0`, `m_last=0`, `done=0`, `remain=0`, `abort_pend=0`, `cmd_ready=0`; partial burst discarded, no `done`.

## Timing
- Command accepted at edge N -> `m_valid=1`, `data_out=cmd_base` from edge N to N+1 onward (1-cycle latency).
- With `s_ready` held high, an L-beat burst occupies L consecutive cycles, one beat per cycle.
- Final transfer at edge M -> `m_valid=0`, `done=1` for cycle M..M+1, `cmd_ready=1` same cycle; next command earliest accepted at edge M+1, data at M+2 (one bubble between bursts).
- `m_valid` never deasserts without a transfer; `m_valid` never depends combinationally on `s_ready`.
- `cmd_ready` is combinational from state and `rst` only.
- `abort` high at edge K (in SEND) -> `m_last=1` from K onward; coincident transfer at edge K of a non-last beat advances normally and the next beat is last.

## Structure
- Shared package/include `rv_pkg`: state encodings `RV_IDLE`, `RV_SEND`; default widths `RV_WD=4`, `RV_LW=4` reused by `rv1` and benches.
- Single module; no sub-module needed (counter and FSM are a few lines each).

## Test plan
- Basic: reset, cmd base=5 len=2, `s_ready=1` -> data 5,6,7 on three consecutive cycles, `m_last` on 7, `done` one cycle after.
- Back-pressure: base=10 len=3, `s_ready` toggling 0/1 -> each of 10,11,12,13 held stable while stalled, transferred exactly once, in order.
- Wrap: base=14 len=3 -> 14,15,0,1; `m_last` on 1.
- Abort: base=0 len=15, assert `abort` while beat 3 stalled -> 3 transferred with `m_last=1`, no beat 4, `done` pulse, `cmd_ready` returns.
- Back-to-back: `cmd_valid` held high with two commands (len=0 each) -> single-beat bursts separated by one idle cycle; `cmd_ready=0` throughout SEND.
- Reset mid-burst: assert `rst` asynchronously during beat 2 of len=4 -> `m_valid`, `data_out`, `m_last`, `done` to 0 immediately, no `done`; new command after release behaves as in Basic.
